// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one fetch outstanding to
// instruction memory, and hands fetched words to the decoder. Any fetch made
// stale by a redirect is dropped.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic        addr_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   addr_d;
    logic [XLEN-1:0]   instr_d;
    logic [XLEN-1:0]   ipc_d;
    logic [XLEN-1:0]   pc4_d;
    logic              req_d;
    logic              valid_d;
    logic              err_d;
    logic              redir_ev;
    logic [XLEN-1:0]   raw_target;
    logic [XLEN-1:0]   target;

    assign imem_addr = addr_q;

    // Redirect source selection: exception beats eret beats branch/jump
    always_comb begin
        redir_ev = exc_valid | eret_valid | redirect_valid;
        if (exc_valid) begin
            raw_target = EXC_VECTOR;
        end else if (eret_valid) begin
            raw_target = epc;
        end else begin
            raw_target = redirect_target;
        end
        target = {raw_target[XLEN-1:2], 2'b00};
    end

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instruction;
        ipc_d   = instr_pc;
        pc4_d   = pc_plus4;
        err_d   = redir_ev && (raw_target[1:0] != 2'b00);

        if (redir_ev) begin
            pc_d = target;
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    if (redir_ev) begin
                        // fetched word is stale; refetch at the target
                        state_d = REQ;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        pc4_d   = pc_q + XLEN'(4);
                        pc_d    = pc_q + XLEN'(4);
                        state_d = HOLD;
                    end
                end else if (redir_ev) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redir_ev || instr_ready) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d   = (state_d == REQ) || (state_d == DROP);
        valid_d = (state_d == HOLD);
        // the in-flight address must stay put until the stale fetch completes
        addr_d  = (state_d == DROP) ? addr_q : pc_d;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instruction <= '0;
            instr_pc    <= '0;
            pc_plus4    <= '0;
            addr_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
            instruction <= instr_d;
            instr_pc    <= ipc_d;
            pc_plus4    <= pc4_d;
            addr_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios with literal
// expectations, then randomized memory latency, backpressure and redirects,
// all compared every cycle against a transaction-level model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0180;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    // model: next fetch address, outstanding fetch, held word
    bit          m_started;
    bit          m_req;
    bit          m_stale;
    bit          m_valid;
    bit          m_err;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    ifetch_unit #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VEC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ack       (imem_ack),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .exc_valid      (exc_valid),
        .eret_valid     (eret_valid),
        .epc            (epc),
        .addr_err       (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0020;
        if (a == 32'h4) return 32'h3C01_FFFF;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_stale   = 1'b0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_pc      = RESET_PC;
        m_addr    = RESET_PC;
        m_instr   = '0;
        m_ipc     = '0;
    endtask

    // advance the model by one clock using the inputs presented this cycle
    task automatic model_update();
        logic        ev;
        logic [31:0] raw;
        ev  = exc_valid | eret_valid | redirect_valid;
        raw = exc_valid ? EXC_VEC : (eret_valid ? epc : redirect_target);
        m_err = ev && (raw[1:0] != 2'b00);
        if (ev) m_pc = raw & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = m_pc;
        end else if (m_req) begin
            if (imem_ack) begin
                if (m_stale || ev) begin
                    m_stale = 1'b0;
                    m_addr  = m_pc;
                end else begin
                    m_valid = 1'b1;
                    m_instr = imem_rdata;
                    m_ipc   = m_addr;
                    m_pc    = m_addr + 32'd4;
                    m_req   = 1'b0;
                end
            end else if (ev) begin
                m_stale = 1'b1;
            end
        end else if (m_valid) begin
            if (ev || instr_ready) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_pc;
            end
        end
    endtask

    task automatic compare_model();
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
        chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        if (m_valid) begin
            chk("instruction", instruction, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
            chk("pc_plus4", pc_plus4, m_ipc + 32'd4);
            chk("mem_content", instruction, mem_word(instr_pc));
        end
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(input bit ack, input bit rdy, input bit [2:0] ev,
                       input logic [31:0] tgt, input logic [31:0] ep);
        imem_ack        = ack;
        imem_rdata      = mem_word(imem_addr);
        instr_ready     = rdy;
        exc_valid       = ev[2];
        eret_valid      = ev[1];
        redirect_valid  = ev[0];
        redirect_target = tgt;
        epc             = ep;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle_inputs();
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        instr_ready     = 1'b0;
        exc_valid       = 1'b0;
        eret_valid      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        epc             = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h0);
        chk("rst_err", {31'b0, addr_err}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          ack;
        bit          rdy;
        bit [2:0]    ev;
        logic [31:0] tgt;
        int          r;

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // sequential fetch, ack two cycles after the request
        cyc(0, 1, 3'b000, 0, 0);
        chk("t1_req", {31'b0, imem_req}, 32'h1);
        chk("t1_addr0", imem_addr, 32'h0);
        cyc(0, 1, 3'b000, 0, 0);
        cyc(0, 1, 3'b000, 0, 0);
        cyc(1, 1, 3'b000, 0, 0);
        chk("t1_valid0", {31'b0, instr_valid}, 32'h1);
        chk("t1_ipc0", instr_pc, 32'h0);
        chk("t1_pc4_0", pc_plus4, 32'h4);
        chk("t1_add", instruction, 32'h0000_0020);
        cyc(0, 1, 3'b000, 0, 0);
        chk("t1_addr4", imem_addr, 32'h4);
        cyc(0, 0, 3'b000, 0, 0);
        cyc(0, 0, 3'b000, 0, 0);
        cyc(1, 0, 3'b000, 0, 0);
        chk("t1_ipc4", instr_pc, 32'h4);
        chk("t1_lui", instruction, 32'h3C01_FFFF);

        // backpressure: word held, no request
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 3'b000, 0, 0);
            chk("t2_hold_ipc", instr_pc, 32'h4);
            chk("t2_hold_instr", instruction, 32'h3C01_FFFF);
            chk("t2_no_req", {31'b0, imem_req}, 32'h0);
        end
        cyc(0, 1, 3'b000, 0, 0);
        chk("t2_req_after", {31'b0, imem_req}, 32'h1);
        chk("t2_addr8", imem_addr, 32'h8);

        // redirect while the fetch to 0x8 is outstanding
        cyc(0, 0, 3'b001, 32'h100, 0);
        chk("t3_drop_addr", imem_addr, 32'h8);
        cyc(0, 0, 3'b000, 0, 0);
        chk("t3_drop_addr2", imem_addr, 32'h8);
        cyc(1, 0, 3'b000, 0, 0);
        chk("t3_no_valid", {31'b0, instr_valid}, 32'h0);
        chk("t3_addr100", imem_addr, 32'h100);
        cyc(1, 1, 3'b000, 0, 0);
        chk("t3_ipc100", instr_pc, 32'h100);

        // simultaneous exception, eret and redirect in HOLD
        cyc(0, 1, 3'b111, 32'h200, 32'h40);
        chk("t4_valid_drop", {31'b0, instr_valid}, 32'h0);
        chk("t4_addr_exc", imem_addr, 32'h180);
        cyc(1, 0, 3'b000, 0, 0);
        cyc(0, 1, 3'b000, 0, 0);
        chk("t4_addr184", imem_addr, 32'h184);

        // misaligned target, then wrap at the top of the address space
        cyc(0, 1, 3'b001, 32'h103, 0);
        chk("t5_err", {31'b0, addr_err}, 32'h1);
        chk("t5_held", imem_addr, 32'h184);
        cyc(1, 1, 3'b000, 0, 0);
        chk("t5_err_once", {31'b0, addr_err}, 32'h0);
        chk("t5_addr100", imem_addr, 32'h100);
        cyc(1, 1, 3'b000, 0, 0);
        cyc(0, 1, 3'b001, 32'hFFFF_FFFC, 0);
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 3'b000, 0, 0);
        chk("t5_ipc_top", instr_pc, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", pc_plus4, 32'h0);
        cyc(0, 1, 3'b000, 0, 0);
        chk("t5_addr_wrap", imem_addr, 32'h0);

        // reset in the middle of a fetch
        rst_n = 1'b0;
        #1;
        chk("t6_req_low", {31'b0, imem_req}, 32'h0);
        chk("t6_valid_low", {31'b0, instr_valid}, 32'h0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 3'b000, 0, 0);
        chk("t6_first_addr", imem_addr, RESET_PC);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset();
            end
            ack = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            r   = $urandom_range(0, 15);
            case (r)
                0:       ev = 3'b100;
                1:       ev = 3'b010;
                2:       ev = 3'b001;
                3:       ev = 3'b111;
                4:       ev = 3'b011;
                default: ev = 3'b000;
            endcase
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            cyc(ack, rdy, ev, tgt, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
